// File: rtl/pdp1_write_if.sv
// Request/memory bundle between the PDP-1 control unit, the write unit and memory.
// Bit 0 of every multi-bit field is the MSB, matching PDP-1 numbering.
interface pdp1_write_if #(
  parameter int W  = 18,
  parameter int AW = 12
);
  logic          wu_valid;
  logic          wu_ready;
  logic [0:4]    wu_op;
  logic [0:AW-1] wu_addr;
  logic [0:W-1]  wu_ac;
  logic [0:W-1]  wu_io;
  logic [0:W-1]  wu_cd;
  logic          mem_req;
  logic [0:AW-1] mem_addr;
  logic [0:W-1]  mem_data;
  logic          mem_ack;
  logic          wu_done;
  logic          wu_acw;
  logic [0:W-1]  wu_acd;
  logic          wu_skp;

  modport master (
    output wu_valid, wu_op, wu_addr, wu_ac, wu_io, wu_cd, mem_ack,
    input  wu_ready, mem_req, mem_addr, mem_data, wu_done, wu_acw, wu_acd, wu_skp
  );

  modport slave (
    input  wu_valid, wu_op, wu_addr, wu_ac, wu_io, wu_cd, mem_ack,
    output wu_ready, mem_req, mem_addr, mem_data, wu_done, wu_acw, wu_acd, wu_skp
  );
endinterface

// File: rtl/pdp1_write_unit.sv
// PDP-1 memory-write unit: CAL/DAC/DAP/DIP/DIO/DZM store paths with an IDLE/WRITE/DONE FSM.
// Define PDP1_WRITE_IDX_EN to also execute IDX and ISZ (ones' complement increment of C(Y)).
`ifndef PDP1_OP_CAL
`define PDP1_OP_CAL 5'o07
`endif
`ifndef PDP1_OP_DAC
`define PDP1_OP_DAC 5'o12
`endif
`ifndef PDP1_OP_DAP
`define PDP1_OP_DAP 5'o13
`endif
`ifndef PDP1_OP_DIP
`define PDP1_OP_DIP 5'o14
`endif
`ifndef PDP1_OP_DIO
`define PDP1_OP_DIO 5'o15
`endif
`ifndef PDP1_OP_DZM
`define PDP1_OP_DZM 5'o16
`endif
`ifndef PDP1_OP_IDX
`define PDP1_OP_IDX 5'o22
`endif
`ifndef PDP1_OP_ISZ
`define PDP1_OP_ISZ 5'o23
`endif

module pdp1_write_unit #(
  parameter int W  = 18,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  pdp1_write_if.slave   wu
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef PDP1_WRITE_IDX_EN
  // Ones' complement +1 with end-around carry; minus zero is normalised to plus zero.
  function automatic logic [0:W-1] ones_inc(input logic [0:W-1] v);
    logic [0:W]   s;
    logic [0:W-1] r;
    s = {1'b0, v} + {{W{1'b0}}, 1'b1};
    if (s[0]) begin
      r = s[1:W] + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r = s[1:W];
    end
    return (r == {W{1'b1}}) ? {W{1'b0}} : r;
  endfunction
`endif

  logic [1:0]    state_q, state_d;
  logic [0:AW-1] addr_q, addr_d;
  logic [0:W-1]  data_q, data_d;
  logic          acw_q, acw_d;
  logic          skp_q, skp_d;

  logic          is_write_s;
  logic [0:W-1]  wdata_s;
  logic          acw_s;
  logic          skp_s;
`ifdef PDP1_WRITE_IDX_EN
  logic [0:W-1]  inc_s;
  assign inc_s = ones_inc(wu.wu_cd);
`endif

  // Opcode decode: write data and retire flags for the presented request.
  always_comb begin
    is_write_s = 1'b0;
    wdata_s    = {W{1'b0}};
    acw_s      = 1'b0;
    skp_s      = 1'b0;
    case (wu.wu_op)
      `PDP1_OP_CAL, `PDP1_OP_DAC: begin
        is_write_s = 1'b1;
        wdata_s    = wu.wu_ac;
      end
      `PDP1_OP_DAP: begin
        is_write_s = 1'b1;
        wdata_s    = {wu.wu_cd[0:W-AW-1], wu.wu_ac[W-AW:W-1]};
      end
      `PDP1_OP_DIP: begin
        is_write_s = 1'b1;
        wdata_s    = {wu.wu_ac[0:W-AW-1], wu.wu_cd[W-AW:W-1]};
      end
      `PDP1_OP_DIO: begin
        is_write_s = 1'b1;
        wdata_s    = wu.wu_io;
      end
      `PDP1_OP_DZM: begin
        is_write_s = 1'b1;
        wdata_s    = {W{1'b0}};
      end
`ifdef PDP1_WRITE_IDX_EN
      `PDP1_OP_IDX: begin
        is_write_s = 1'b1;
        wdata_s    = inc_s;
        acw_s      = 1'b1;
      end
      `PDP1_OP_ISZ: begin
        is_write_s = 1'b1;
        wdata_s    = inc_s;
        skp_s      = ~inc_s[0];
      end
`endif
      default: begin
        is_write_s = 1'b0;
        wdata_s    = {W{1'b0}};
      end
    endcase
  end

  // Next-state logic; operands are captured only on acceptance so they stay stable in WRITE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    acw_d   = acw_q;
    skp_d   = skp_q;
    case (state_q)
      ST_IDLE: begin
        if (wu.wu_valid) begin
          addr_d  = wu.wu_addr;
          data_d  = wdata_s;
          acw_d   = acw_s;
          skp_d   = skp_s;
          state_d = is_write_s ? ST_WRITE : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wu.mem_ack) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {AW{1'b0}};
      data_q  <= {W{1'b0}};
      acw_q   <= 1'b0;
      skp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      acw_q   <= acw_d;
      skp_q   <= skp_d;
    end
  end

  // Outputs decode the state register only, so reset takes effect without a clock.
  assign wu.wu_ready = (state_q == ST_IDLE);
  assign wu.mem_req  = (state_q == ST_WRITE);
  assign wu.wu_done  = (state_q == ST_DONE);
  assign wu.wu_acw   = (state_q == ST_DONE) & acw_q;
  assign wu.wu_skp   = (state_q == ST_DONE) & skp_q;
  assign wu.mem_addr = addr_q;
  assign wu.mem_data = data_q;
  assign wu.wu_acd   = data_q;

endmodule

// File: tb/tb_pdp1_write_unit.sv
// Directed self-checking bench for pdp1_write_unit (W=18, AW=12); IDX/ISZ checks follow PDP1_WRITE_IDX_EN.
module tb_pdp1_write_unit;
  localparam logic [4:0] OP_CAL = 5'o07;
  localparam logic [4:0] OP_LAC = 5'o10;
  localparam logic [4:0] OP_DAC = 5'o12;
  localparam logic [4:0] OP_DAP = 5'o13;
  localparam logic [4:0] OP_DIP = 5'o14;
  localparam logic [4:0] OP_DIO = 5'o15;
  localparam logic [4:0] OP_DZM = 5'o16;
  localparam logic [4:0] OP_UNK = 5'o17;
  localparam logic [4:0] OP_IDX = 5'o22;
  localparam logic [4:0] OP_ISZ = 5'o23;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   n_done;

  pdp1_write_if #(.W(18), .AW(12)) wu_if ();

  pdp1_write_unit #(.W(18), .AW(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wu    (wu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
  endtask

  task automatic drive(input logic [4:0] op, input logic [11:0] addr,
                       input logic [17:0] ac, input logic [17:0] io, input logic [17:0] cd);
    wu_if.wu_valid = 1'b1;
    wu_if.wu_op    = op;
    wu_if.wu_addr  = addr;
    wu_if.wu_ac    = ac;
    wu_if.wu_io    = io;
    wu_if.wu_cd    = cd;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    n_done = 0;
    rst_n  = 1'b0;
    wu_if.wu_valid = 1'b0;
    wu_if.wu_op    = 5'o00;
    wu_if.wu_addr  = 12'o0;
    wu_if.wu_ac    = 18'o0;
    wu_if.wu_io    = 18'o0;
    wu_if.wu_cd    = 18'o0;
    wu_if.mem_ack  = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_ready", wu_if.wu_ready, 36'd1);
    chk("rst_req",   wu_if.mem_req,  36'd0);
    chk("rst_done",  wu_if.wu_done,  36'd0);
    chk("rst_acw",   wu_if.wu_acw,   36'd0);
    chk("rst_skp",   wu_if.wu_skp,   36'd0);
    chk("rst_addr",  wu_if.mem_addr, 36'd0);
    chk("rst_data",  wu_if.mem_data, 36'd0);
    chk("rst_acd",   wu_if.wu_acd,   36'd0);

    // DAC right after reset release, mem_ack tied high
    rst_n = 1'b1;
    wu_if.mem_ack = 1'b1;
    drive(OP_DAC, 12'o0100, 18'o123456, 18'o0, 18'o0);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("dac_req",   wu_if.mem_req,  36'd1);
    chk("dac_addr",  wu_if.mem_addr, 36'o0100);
    chk("dac_data",  wu_if.mem_data, 36'o123456);
    chk("dac_ready", wu_if.wu_ready, 36'd0);
    chk("dac_ndone", wu_if.wu_done,  36'd0);
    @(negedge clk);
    chk("dac_req_off", wu_if.mem_req, 36'd0);
    chk("dac_done",    wu_if.wu_done, 36'd1);
    chk("dac_acw",     wu_if.wu_acw,  36'd0);
    chk("dac_skp",     wu_if.wu_skp,  36'd0);
    @(negedge clk);
    chk("dac_done_off", wu_if.wu_done,  36'd0);
    chk("dac_idle",     wu_if.wu_ready, 36'd1);

    // CAL stores AC
    drive(OP_CAL, 12'o0101, 18'o654321, 18'o0, 18'o0);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("cal_data", wu_if.mem_data, 36'o654321);
    @(negedge clk);
    chk("cal_done", wu_if.wu_done, 36'd1);
    @(negedge clk);

    // DAP / DIP field merges
    drive(OP_DAP, 12'o0200, 18'o777777, 18'o0, 18'o000000);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("dap_req",  wu_if.mem_req,  36'd1);
    chk("dap_data", wu_if.mem_data, 36'o007777);
    @(negedge clk);
    chk("dap_done", wu_if.wu_done, 36'd1);
    @(negedge clk);
    drive(OP_DIP, 12'o0201, 18'o777777, 18'o0, 18'o000000);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("dip_data", wu_if.mem_data, 36'o770000);
    chk("dip_addr", wu_if.mem_addr, 36'o0201);
    @(negedge clk);
    chk("dip_done", wu_if.wu_done, 36'd1);

    // mem_ack high while idle has no effect
    @(negedge clk);
    chk("idle_ack_ready", wu_if.wu_ready, 36'd1);
    @(negedge clk);
    chk("idle_ack_req",  wu_if.mem_req, 36'd0);
    chk("idle_ack_done", wu_if.wu_done, 36'd0);

    // DZM with mem_ack withheld for 5 cycles, a second request held during the stall
    wu_if.mem_ack = 1'b0;
    drive(OP_DZM, 12'o0300, 18'o555555, 18'o555555, 18'o555555);
    @(negedge clk);
    drive(OP_DAC, 12'o0777, 18'o111111, 18'o0, 18'o0);
    for (int i = 0; i < 5; i++) begin
      chk("dzm_req",   wu_if.mem_req,  36'd1);
      chk("dzm_data",  wu_if.mem_data, 36'd0);
      chk("dzm_ready", wu_if.wu_ready, 36'd0);
      chk("dzm_addr",  wu_if.mem_addr, 36'o0300);
      chk("dzm_ndone", wu_if.wu_done,  36'd0);
      if (i < 4) @(negedge clk);
    end
    wu_if.mem_ack  = 1'b1;
    wu_if.wu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wu_if.wu_done === 1'b1) n_done++;
    end
    chk("dzm_done_count", n_done,           36'd1);
    chk("dzm_addr_kept",  wu_if.mem_addr,   36'o0300);
    chk("dzm_end_ready",  wu_if.wu_ready,   36'd1);

    // reset pulse during a DIO write aborts it
    wu_if.mem_ack = 1'b0;
    drive(OP_DIO, 12'o0400, 18'o0, 18'o246135, 18'o0);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("dio_req",  wu_if.mem_req,  36'd1);
    chk("dio_data", wu_if.mem_data, 36'o246135);
    #2;
    rst_n = 1'b0;
    #1;
    chk("dio_rst_req",   wu_if.mem_req,  36'd0);
    chk("dio_rst_ready", wu_if.wu_ready, 36'd1);
    chk("dio_rst_data",  wu_if.mem_data, 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wu_if.mem_ack = 1'b1;
    chk("dio_rel_done", wu_if.wu_done, 36'd0);
    @(negedge clk);
    chk("dio_rel_done2", wu_if.wu_done,  36'd0);
    chk("dio_rel_ready", wu_if.wu_ready, 36'd1);

    // unknown opcode retires in 2 cycles with no write
    drive(OP_UNK, 12'o0500, 18'o111111, 18'o222222, 18'o333333);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("unk_done",  wu_if.wu_done,  36'd1);
    chk("unk_req",   wu_if.mem_req,  36'd0);
    chk("unk_acw",   wu_if.wu_acw,   36'd0);
    chk("unk_skp",   wu_if.wu_skp,   36'd0);
    chk("unk_ready", wu_if.wu_ready, 36'd0);
    @(negedge clk);
    chk("unk_idle", wu_if.wu_ready, 36'd1);

    // non-store op (LAC) also retires in 2 cycles
    drive(OP_LAC, 12'o0501, 18'o111111, 18'o0, 18'o0);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("lac_done", wu_if.wu_done, 36'd1);
    chk("lac_req",  wu_if.mem_req, 36'd0);
    @(negedge clk);

`ifdef PDP1_WRITE_IDX_EN
    // IDX: -1 + 1 gives minus zero, normalised to 0
    drive(OP_IDX, 12'o0600, 18'o0, 18'o0, 18'o777776);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("idx_req",  wu_if.mem_req,  36'd1);
    chk("idx_data", wu_if.mem_data, 36'd0);
    @(negedge clk);
    chk("idx_done", wu_if.wu_done, 36'd1);
    chk("idx_acw",  wu_if.wu_acw,  36'd1);
    chk("idx_acd",  wu_if.wu_acd,  36'd0);
    chk("idx_skp",  wu_if.wu_skp,  36'd0);
    @(negedge clk);
    chk("idx_acw_off", wu_if.wu_acw, 36'd0);
    // ISZ: minus zero + 1 with end-around carry gives +1, skip
    drive(OP_ISZ, 12'o0601, 18'o0, 18'o0, 18'o777777);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("isz_data", wu_if.mem_data, 36'o000001);
    @(negedge clk);
    chk("isz_skp", wu_if.wu_skp, 36'd1);
    chk("isz_acw", wu_if.wu_acw, 36'd0);
    @(negedge clk);
    // ISZ on a negative value: no skip
    drive(OP_ISZ, 12'o0602, 18'o0, 18'o0, 18'o400000);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("isz_neg_data", wu_if.mem_data, 36'o400001);
    @(negedge clk);
    chk("isz_neg_done", wu_if.wu_done, 36'd1);
    chk("isz_neg_skp",  wu_if.wu_skp,  36'd0);
    @(negedge clk);
`else
    // IDX/ISZ behave as unknown opcodes
    drive(OP_IDX, 12'o0600, 18'o0, 18'o0, 18'o777776);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("idx_off_done", wu_if.wu_done, 36'd1);
    chk("idx_off_req",  wu_if.mem_req, 36'd0);
    chk("idx_off_acw",  wu_if.wu_acw,  36'd0);
    chk("idx_off_skp",  wu_if.wu_skp,  36'd0);
    @(negedge clk);
    drive(OP_ISZ, 12'o0601, 18'o0, 18'o0, 18'o777777);
    @(negedge clk);
    wu_if.wu_valid = 1'b0;
    chk("isz_off_done", wu_if.wu_done, 36'd1);
    chk("isz_off_req",  wu_if.mem_req, 36'd0);
    chk("isz_off_skp",  wu_if.wu_skp,  36'd0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pdp1_write_unit.md
PDP1_WRITE_UNIT -- requirements
Module: pdp1_write_unit

Interface
REQ-001 Parameter W, default 18, word width in bits; legal range 12..36.
REQ-002 Parameter AW, default 12, address-part width; SHALL be less than W.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wu_valid  in  1  request strobe; the request is accepted on a cycle where wu_valid and wu_ready are both 1.
REQ-006 wu_ready  out  1  unit can accept a request.
REQ-007 wu_op  in  [0:4]  instruction opcode, encoded with the shared PDP1_OP_* macros.
REQ-008 wu_addr  in  [0:AW-1]  effective memory address.
REQ-009 wu_ac, wu_io, wu_cd  in  [0:W-1] each  AC, IO and current memory contents C(Y); bit 0 is the MSB and sign.
REQ-010 mem_req  out  1  memory write request.
REQ-011 mem_addr  out  [0:AW-1]  write address.
REQ-012 mem_data  out  [0:W-1]  write data.
REQ-013 mem_ack  in  1  memory accepted the write.
REQ-014 wu_done  out  1  one-cycle pulse when a request retires.
REQ-015 wu_acw  out  1  qualifies wu_acd; valid in the same cycle as wu_done.
REQ-016 wu_acd  out  [0:W-1]  value to load into AC.
REQ-017 wu_skp  out  1  skip-next-instruction flag; valid in the same cycle as wu_done.

Function
REQ-018 The FSM SHALL have three states: IDLE, WRITE and DONE. wu_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance, the unit SHALL register wu_addr and the computed write data and flags in that same cycle.
- Write op: next state WRITE.
- Any other op: next state DONE, with no memory request.
REQ-020 Write data SHALL be computed as follows:
- CAL, DAC: AC.
- DAP: {cd[0:W-AW-1], ac[W-AW:W-1]}.
- DIP: {ac[0:W-AW-1], cd[W-AW:W-1]}.
- DIO: IO.
- DZM: all zeros.
REQ-021 In WRITE, mem_req SHALL be 1, and mem_addr/mem_data SHALL hold their registered values stable until the cycle in which mem_ack is 1. That cycle transitions to DONE.
REQ-022 mem_ack sampled while the unit is not in WRITE SHALL be ignored.
REQ-023 DONE SHALL last exactly one cycle: wu_done = 1, then return to IDLE.
- Minimum latency for a write op: acceptance, WRITE, DONE (3 cycles when mem_ack is returned in the first WRITE cycle).
- Minimum latency for a non-write op: 2 cycles.
REQ-024 Outside DONE, wu_acw and wu_skp SHALL be 0. For CAL, DAC, DAP, DIP, DIO and DZM, they SHALL also be 0 in DONE.
REQ-025 Requests presented while wu_ready is 0 SHALL NOT be accepted, and the unit SHALL NOT alter them.
REQ-026 An unknown opcode SHALL retire through DONE with no memory write and all flags 0.

Reset
REQ-027 When rst_n = 0, the unit SHALL immediately return to IDLE and force all outputs to their reset values:
- wu_ready = 1.
- mem_req, wu_done, wu_acw, wu_skp = 0.
- mem_addr, mem_data, wu_acd = 0.
REQ-028 A reset asserted during WRITE SHALL abort the transfer: mem_req drops asynchronously and no wu_done pulse is produced.
REQ-029 The first acceptance SHALL be possible in the first rising edge after rst_n deasserts.

Configuration
REQ-030 When the macro PDP1_WRITE_IDX_EN is defined, IDX and ISZ SHALL be write ops.
- Write data: C(Y)+1 in ones' complement with end-around carry. A result of all ones (minus zero) SHALL be replaced by all zeros.
- IDX: in DONE, wu_acw = 1 and wu_acd = the write data.
- ISZ: in DONE, wu_skp = 1 when bit 0 of the write data is 0.
REQ-031 When PDP1_WRITE_IDX_EN is not defined, IDX and ISZ SHALL be handled as unknown opcodes per REQ-026.

Verification
REQ-032 Reset, then DAC with ac=0o123456, addr=0o0100, mem_ack tied 1. Required: mem_req for 1 cycle with data 0o123456 and addr 0o0100, then wu_done 1 cycle later.
REQ-033 DAP with ac=0o777777, cd=0o000000 (W=18, AW=12). Required: mem_data = 0o007777. DIP with the same inputs: mem_data = 0o770000.
REQ-034 DZM with mem_ack held 0 for 5 cycles. Required: mem_req stays 1, mem_data = 0 and wu_ready = 0 throughout. After mem_ack, exactly one wu_done.
REQ-035 PDP1_WRITE_IDX_EN defined:
- IDX with cd=0o777776. Required: mem_data = 0, wu_acd = 0, wu_acw = 1.
- ISZ with cd=0o777777. Required: mem_data = 0o000001, wu_skp = 1.
REQ-036 rst_n pulsed low during WRITE of DIO. Required: mem_req falls without waiting for a clock edge, no wu_done, and wu_ready = 1 after release.
REQ-037 Unknown opcode, and IDX with PDP1_WRITE_IDX_EN undefined. Required for each: no mem_req, wu_done after 2 cycles, all flags 0.
